// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   Oversampling 8N1 UART receiver, LSB first. Every good byte appears on
//   rx_data together with a one-cycle rx_valid strobe. A frame whose stop bit
//   is sampled low is dropped and reported with a one-cycle frame_err strobe.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   rx_data    last good byte, held between frames
//   rx_valid   one-cycle strobe, rx_data is new on this cycle
//   frame_err  one-cycle strobe, stop bit was low
//   busy       high while a frame is being received
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t          state, state_d;
    logic            rx_m, rx_s;
    logic [CW-1:0]   bit_cnt, cnt_d;
    logic [2:0]      bit_idx, idx_d;
    logic [7:0]      shreg, sh_d;
    logic [7:0]      data_d;
    logic            valid_d, err_d, busy_d;
    logic            in_frame, in_frame_d;

    // Reset to 1 so the synchronizer looks idle coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= cnt_d;
            bit_idx   <= idx_d;
            shreg     <= sh_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= err_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt;
        idx_d   = bit_idx;
        sh_d    = shreg;
        data_d  = rx_data;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            // A low line here is either stuck or mid-frame; never a start bit.
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            // Re-check the start bit at its centre to reject glitches.
            START: begin
                cnt_d = bit_cnt + CW'(1);
                if (bit_cnt == CNT_HALF) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            // Counting from the start-bit centre puts every sample mid-bit.
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    sh_d  = {rx_s, shreg[7:1]};
                    cnt_d = '0;
                    idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = bit_cnt + CW'(1);
                end
            end
            // Leaving at the stop-bit centre leaves half a bit to catch the
            // next start edge in IDLE.
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    if (rx_s) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = bit_cnt + CW'(1);
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // busy rises one cycle after START is entered and drops on the same
    // cycle as the end-of-frame strobe.
    assign in_frame   = (state == START) || (state == DATA) || (state == STOP);
    assign in_frame_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    assign busy_d     = in_frame && in_frame_d;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_strobe = 0;
    int         cyc = 0;
    int         t_prev = 0;
    int         t_last = 0;
    int         s;
    logic       ignore = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard monitor: every strobe is matched against the next expected frame.
    always @(negedge clk) begin
        cyc++;
        if (rx_valid || frame_err) begin
            n_strobe++;
            if (!ignore) begin
                chk("strobe_excl", 32'(rx_valid && frame_err), 0);
                chk("busy_at_strobe", 32'(busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(rx_valid | frame_err), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", 32'(frame_err), 32'(e.err));
                    chk(e.err ? "err_data_held" : "rx_data", 32'(rx_data), 32'(e.data));
                    if (rx_valid) begin
                        t_prev = t_last;
                        t_last = cyc;
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        if (stop) begin
            exp_q.push_back('{err: 1'b0, data: b});
            exp_data = b;
        end else begin
            exp_q.push_back('{err: 1'b1, data: exp_data});
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        idle(40);

        // single byte
        send_byte(8'h05);
        idle(20);
        drain();
        chk("busy_after_05", 32'(busy), 0);
        chk("hold_05", 32'(rx_data), 32'h05);

        // back-to-back frames, one stop bit each
        send_byte(8'hA5);
        send_byte(8'h3C);
        idle(20);
        drain();
        chk("b2b_gap", 32'(t_last - t_prev), 160);

        // short low glitch must not start a frame
        s = n_strobe;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(40);
        chk("glitch_no_strobe", 32'(n_strobe - s), 0);
        chk("glitch_busy", 32'(busy), 0);
        send_byte(8'h0F);
        idle(20);
        drain();

        // bad stop bit, line held low afterwards
        send_byte(8'h12, 1'b0);
        drain();
        s = n_strobe;
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("low_no_start", 32'(n_strobe - s), 0);
        chk("low_busy", 32'(busy), 0);
        idle(CPB);
        send_byte(8'h07);
        idle(20);
        drain();

        // reset pulse in the middle of data bit 3 of 0x55
        s = n_strobe;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        exp_data = 8'h00;
        idle(3 * CPB);
        chk("midrst_no_strobe", 32'(n_strobe - s), 0);
        send_byte(8'h0A);
        idle(20);
        drain();

        // line held low through reset release
        rx  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s = n_strobe;
        repeat (50) @(negedge clk);
        chk("lowrst_no_strobe", 32'(n_strobe - s), 0);
        // once the line goes high the outcome of the stale frame is don't-care
        ignore = 1'b1;
        idle(300);
        ignore = 1'b0;
        send_byte(8'h0B);
        idle(20);
        drain();
        chk("final_0B", 32'(rx_data), 32'h0B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
